// File: rtl/hid_report_scheduler_if.sv
// rtl/hid_report_scheduler_if.sv - HID host-core inputs and spi_io-facing status bundle
interface hid_report_scheduler_if;
  logic              hid_read;
  logic              kb_connected;
  logic              kb_report_valid;
  logic [7:0]        kb_modifiers;
  logic [0:5][7:0]   kb_keycodes;
  logic              ms_connected;
  logic              ms_report_valid;
  logic [7:0]        ms_buttons;
  logic signed [15:0] ms_dx;
  logic signed [15:0] ms_dy;
  logic signed [7:0]  ms_dwheel;

  logic              hid_keyboard_connected;
  logic              hid_mouse_connected;
  logic [7:0]        hid_keyboard_modifiers;
  logic [0:5][7:0]   hid_keyboard_keycodes;
  logic [7:0]        hid_mouse_buttons;
  logic signed [31:0] hid_mouse_x;
  logic signed [31:0] hid_mouse_y;
  logic signed [31:0] hid_mouse_wheel;
  logic              snapshot_busy;

  modport master (
    output hid_read, kb_connected, kb_report_valid, kb_modifiers, kb_keycodes,
           ms_connected, ms_report_valid, ms_buttons, ms_dx, ms_dy, ms_dwheel,
    input  hid_keyboard_connected, hid_mouse_connected, hid_keyboard_modifiers,
           hid_keyboard_keycodes, hid_mouse_buttons, hid_mouse_x, hid_mouse_y,
           hid_mouse_wheel, snapshot_busy
  );

  modport slave (
    input  hid_read, kb_connected, kb_report_valid, kb_modifiers, kb_keycodes,
           ms_connected, ms_report_valid, ms_buttons, ms_dx, ms_dy, ms_dwheel,
    output hid_keyboard_connected, hid_mouse_connected, hid_keyboard_modifiers,
           hid_keyboard_keycodes, hid_mouse_buttons, hid_mouse_x, hid_mouse_y,
           hid_mouse_wheel, snapshot_busy
  );
endinterface

// File: rtl/hid_report_scheduler.sv
// rtl/hid_report_scheduler.sv - HID report accumulator with snapshot freeze/commit for spi_io
// Define HID_SCHED_SATURATE_EN for saturating accumulate/commit; default is two's-complement wrap.
module hid_report_scheduler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  hid_report_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, COMMIT} state_e;

  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
`ifdef HID_SCHED_SATURATE_EN
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    return (s[32] ^ s[31]) ? {s[32], {31{~s[32]}}} : s[31:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [31:0] acc_sub(input logic [31:0] a, input logic [31:0] b);
`ifdef HID_SCHED_SATURATE_EN
    logic [32:0] s;
    s = {a[31], a} - {b[31], b};
    return (s[32] ^ s[31]) ? {s[32], {31{~s[32]}}} : s[31:0];
`else
    return a - b;
`endif
  endfunction

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic                   rd_s;

  logic [7:0]      kb_mod_q;
  logic [0:5][7:0] kb_keys_q;
  logic [7:0]      ms_btn_q;
  logic [31:0]     acc_x_q, acc_y_q, acc_w_q;
  logic [31:0]     acc_x_d, acc_y_d, acc_w_d;
  logic [31:0]     base_x, base_y, base_w;
  logic [31:0]     snap_x_q, snap_y_q, snap_w_q;
  logic [31:0]     dx_ext, dy_ext, dw_ext;

  logic            out_kconn_q, out_mconn_q, busy_q;
  logic [7:0]      out_kmod_q, out_btn_q;
  logic [0:5][7:0] out_keys_q;
  logic [31:0]     out_x_q, out_y_q, out_w_q;

  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign dx_ext = {{16{bus.ms_dx[15]}}, bus.ms_dx};
  assign dy_ext = {{16{bus.ms_dy[15]}}, bus.ms_dy};
  assign dw_ext = {{24{bus.ms_dwheel[7]}}, bus.ms_dwheel};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sync_q <= '0;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], bus.hid_read};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.kb_connected) begin
      kb_mod_q  <= '0;
      kb_keys_q <= '0;
    end else if (bus.kb_report_valid) begin
      kb_mod_q  <= bus.kb_modifiers;
      kb_keys_q <= bus.kb_keycodes;
    end
  end

  // COMMIT retires the reported snapshot before folding in any same-cycle delta.
  always_comb begin
    base_x = acc_x_q;
    base_y = acc_y_q;
    base_w = acc_w_q;
    if (state_q == COMMIT) begin
      base_x = acc_sub(acc_x_q, snap_x_q);
      base_y = acc_sub(acc_y_q, snap_y_q);
      base_w = acc_sub(acc_w_q, snap_w_q);
    end
    acc_x_d = base_x;
    acc_y_d = base_y;
    acc_w_d = base_w;
    if (bus.ms_report_valid) begin
      acc_x_d = acc_add(base_x, dx_ext);
      acc_y_d = acc_add(base_y, dy_ext);
      acc_w_d = acc_add(base_w, dw_ext);
    end
    if (!bus.ms_connected) begin
      acc_x_d = '0;
      acc_y_d = '0;
      acc_w_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_btn_q <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      acc_w_q  <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      acc_w_q <= acc_w_d;
      if (!bus.ms_connected) begin
        ms_btn_q <= '0;
      end else if (bus.ms_report_valid) begin
        ms_btn_q <= bus.ms_buttons;
      end
    end
  end

  // The snapshot is taken on the edge entering CAPTURE so freeze and busy coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_w_q    <= '0;
      out_kconn_q <= 1'b0;
      out_mconn_q <= 1'b0;
      out_kmod_q  <= '0;
      out_keys_q  <= '0;
      out_btn_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_w_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_kconn_q <= bus.kb_connected;
          out_mconn_q <= bus.ms_connected;
          out_kmod_q  <= kb_mod_q;
          out_keys_q  <= kb_keys_q;
          out_btn_q   <= ms_btn_q;
          out_x_q     <= acc_x_q;
          out_y_q     <= acc_y_q;
          out_w_q     <= acc_w_q;
          if (rd_s) begin
            snap_x_q <= acc_x_q;
            snap_y_q <= acc_y_q;
            snap_w_q <= acc_w_q;
            busy_q   <= 1'b1;
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: state_q <= HOLD;
        HOLD: begin
          if (!rd_s) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A disconnect voids the pending snapshot so COMMIT cannot subtract stale motion.
      if (!bus.ms_connected) begin
        snap_x_q <= '0;
        snap_y_q <= '0;
        snap_w_q <= '0;
      end
    end
  end

  assign bus.hid_keyboard_connected = out_kconn_q;
  assign bus.hid_mouse_connected    = out_mconn_q;
  assign bus.hid_keyboard_modifiers = out_kmod_q;
  assign bus.hid_keyboard_keycodes  = out_keys_q;
  assign bus.hid_mouse_buttons      = out_btn_q;
  assign bus.hid_mouse_x            = out_x_q;
  assign bus.hid_mouse_y            = out_y_q;
  assign bus.hid_mouse_wheel        = out_w_q;
  assign bus.snapshot_busy          = busy_q;

endmodule

// File: tb/tb_hid_report_scheduler.sv
// tb/tb_hid_report_scheduler.sv - bench for hid_report_scheduler (directed + randomized vs model)
module tb_hid_report_scheduler;
  localparam int SS = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  int          m_x, m_y, m_w, s_x, s_y, s_w;
  logic [7:0]  m_btn, m_kmod;
  logic [47:0] m_keys;
  logic        m_kconn, m_mconn;
  int          f_x, f_y, f_w;
  logic [7:0]  f_btn, f_kmod;
  logic [47:0] f_keys;
  logic        f_kconn, f_mconn;

  hid_report_scheduler_if bus ();

  hid_report_scheduler #(.SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input longint s);
`ifdef HID_SCHED_SATURATE_EN
    if (s > MAXV) return int'(MAXV);
    if (s < MINV) return int'(MINV);
`endif
    return int'(s);
  endfunction

  function automatic int m_add(input int a, input int b);
    return clamp(longint'(a) + longint'(b));
  endfunction

  function automatic int m_sub(input int a, input int b);
    return clamp(longint'(a) - longint'(b));
  endfunction

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] w, input logic [7:0] btn, input logic mc,
                               input logic kc, input logic [7:0] km, input logic [47:0] keys);
    logic [31:0] ox, oy, ow;
    logic [47:0] okeys;
    ox = bus.hid_mouse_x;
    oy = bus.hid_mouse_y;
    ow = bus.hid_mouse_wheel;
    okeys = bus.hid_keyboard_keycodes;
    chk({tag, ".x"}, ox, x);
    chk({tag, ".y"}, oy, y);
    chk({tag, ".w"}, ow, w);
    chk({tag, ".btn"}, bus.hid_mouse_buttons, btn);
    chk({tag, ".mconn"}, bus.hid_mouse_connected, mc);
    chk({tag, ".kconn"}, bus.hid_keyboard_connected, kc);
    chk({tag, ".kmod"}, bus.hid_keyboard_modifiers, km);
    chk({tag, ".keys"}, okeys, keys);
  endtask

  task automatic check_live(input string tag);
    check_outputs(tag, m_x, m_y, m_w, m_btn, m_mconn, m_kconn, m_kmod, m_keys);
  endtask

  task automatic check_frozen(input string tag);
    check_outputs(tag, f_x, f_y, f_w, f_btn, f_mconn, f_kconn, f_kmod, f_keys);
  endtask

  task automatic ms_pulse(input logic [15:0] dx, input logic [15:0] dy,
                          input logic [7:0] dw, input logic [7:0] btn);
    bus.ms_dx = dx;
    bus.ms_dy = dy;
    bus.ms_dwheel = dw;
    bus.ms_buttons = btn;
    bus.ms_report_valid = 1'b1;
    tick();
    bus.ms_report_valid = 1'b0;
    if (m_mconn) begin
      m_x = m_add(m_x, sx16(dx));
      m_y = m_add(m_y, sx16(dy));
      m_w = m_add(m_w, sx8(dw));
      m_btn = btn;
    end
  endtask

  task automatic kb_pulse(input logic [7:0] km, input logic [47:0] keys);
    bus.kb_modifiers = km;
    bus.kb_keycodes = keys;
    bus.kb_report_valid = 1'b1;
    tick();
    bus.kb_report_valid = 1'b0;
    if (m_kconn) begin
      m_kmod = km;
      m_keys = keys;
    end
  endtask

  task automatic begin_txn(input string tag);
    bus.hid_read = 1'b1;
    repeat (SS) tick();
    chk({tag, ".busy_pre"}, bus.snapshot_busy, 1'b0);
    tick();
    f_x = m_x; f_y = m_y; f_w = m_w; f_btn = m_btn;
    f_kmod = m_kmod; f_keys = m_keys; f_kconn = m_kconn; f_mconn = m_mconn;
    s_x = m_x; s_y = m_y; s_w = m_w;
    chk({tag, ".busy_cap"}, bus.snapshot_busy, 1'b1);
    check_frozen({tag, ".cap"});
  endtask

  task automatic end_txn(input string tag, input bit rep, input logic [15:0] dx,
                         input logic [15:0] dy, input logic [7:0] dw, input logic [7:0] btn);
    bus.hid_read = 1'b0;
    repeat (SS + 1) tick();
    chk({tag, ".busy_commit"}, bus.snapshot_busy, 1'b1);
    if (rep) begin
      bus.ms_dx = dx; bus.ms_dy = dy; bus.ms_dwheel = dw; bus.ms_buttons = btn;
      bus.ms_report_valid = 1'b1;
    end
    tick();
    bus.ms_report_valid = 1'b0;
    if (m_mconn) begin
      m_x = m_sub(m_x, s_x);
      m_y = m_sub(m_y, s_y);
      m_w = m_sub(m_w, s_w);
      if (rep) begin
        m_x = m_add(m_x, sx16(dx));
        m_y = m_add(m_y, sx16(dy));
        m_w = m_add(m_w, sx8(dw));
        m_btn = btn;
      end
    end
    chk({tag, ".busy_idle"}, bus.snapshot_busy, 1'b0);
    check_frozen({tag, ".exit"});
    tick();
    check_live({tag, ".post"});
  endtask

  task automatic mouse_clear();
    bus.ms_connected = 1'b0;
    tick();
    bus.ms_connected = 1'b1;
    m_x = 0; m_y = 0; m_w = 0; m_btn = '0;
    tick();
  endtask

  initial begin
    logic [31:0] ov_exp, ox;
    reset = 1'b1;
    bus.hid_read = 1'b0;
    bus.kb_connected = 1'b0; bus.kb_report_valid = 1'b0;
    bus.kb_modifiers = '0; bus.kb_keycodes = '0;
    bus.ms_connected = 1'b0; bus.ms_report_valid = 1'b0;
    bus.ms_buttons = '0; bus.ms_dx = '0; bus.ms_dy = '0; bus.ms_dwheel = '0;
    m_x = 0; m_y = 0; m_w = 0; m_btn = '0; m_kmod = '0; m_keys = '0;
    m_kconn = 1'b0; m_mconn = 1'b0;
    repeat (3) tick();
    check_live("reset");
    chk("reset.busy", bus.snapshot_busy, 1'b0);

    reset = 1'b0;
    bus.kb_connected = 1'b1; bus.ms_connected = 1'b1;
    m_kconn = 1'b1; m_mconn = 1'b1;
    repeat (2) tick();
    check_live("connect");

    // Two reports in IDLE: output lags the accumulator by one register
    ms_pulse(16'd5, 16'd0, 8'd0, 8'h01);
    ms_pulse(16'hFFFD, 16'd0, 8'd0, 8'h01);
    ox = bus.hid_mouse_x;
    chk("idle.latency_x", ox, 32'd5);
    tick();
    ox = bus.hid_mouse_x;
    chk("idle.sum_x", ox, 32'd2);
    check_live("idle");

    kb_pulse(8'h22, 48'h04_05_06_07_08_09);
    tick();
    check_live("kb");

    // Motion arriving while HOLD is frozen is kept for the next transaction
    ms_pulse(16'd8, 16'd3, 8'hFF, 8'h02);
    tick();
    begin_txn("hold");
    ms_pulse(16'd7, 16'd0, 8'd0, 8'h02);
    repeat (3) tick();
    ox = bus.hid_mouse_x;
    chk("hold.frozen_x", ox, 32'd10);
    check_frozen("hold");
    end_txn("hold", 1'b0, '0, '0, '0, '0);
    ox = bus.hid_mouse_x;
    chk("hold.after_x", ox, 32'd7);

    ms_pulse(16'd3, 16'd0, 8'd0, 8'h02);
    tick();
    begin_txn("commit_rep");
    repeat (2) tick();
    end_txn("commit_rep", 1'b1, 16'd4, 16'd0, 8'd0, 8'h02);
    ox = bus.hid_mouse_x;
    chk("commit_rep.x", ox, 32'd4);

    bus.kb_connected = 1'b0;
    m_kconn = 1'b0; m_kmod = '0; m_keys = '0;
    kb_pulse(8'h55, 48'h11_22_33_44_55_66);
    tick();
    check_live("kb_disc");
    bus.kb_connected = 1'b1;
    m_kconn = 1'b1;
    tick();

    // Mouse unplugged mid-transaction
    ms_pulse(16'd46, 16'd0, 8'd0, 8'h04);
    tick();
    begin_txn("disc");
    bus.ms_connected = 1'b0;
    m_mconn = 1'b0; m_x = 0; m_y = 0; m_w = 0; m_btn = '0; s_x = 0; s_y = 0; s_w = 0;
    repeat (2) tick();
    ox = bus.hid_mouse_x;
    chk("disc.frozen_x", ox, 32'd50);
    chk("disc.frozen_conn", bus.hid_mouse_connected, 1'b1);
    end_txn("disc", 1'b0, '0, '0, '0, '0);
    ox = bus.hid_mouse_x;
    chk("disc.x", ox, 32'd0);
    chk("disc.conn", bus.hid_mouse_connected, 1'b0);
    bus.ms_connected = 1'b1;
    m_mconn = 1'b1;
    tick();

    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        ms_pulse(16'($urandom()), 16'($urandom()), 8'($urandom()), 8'($urandom()));
        if ($urandom_range(0, 1) == 1) tick();
      end
      if ($urandom_range(0, 2) == 0) kb_pulse(8'($urandom()), {$urandom(), 16'($urandom())});
      tick();
      check_live("rand_idle");
      if ($urandom_range(0, 1) == 1) begin
        begin_txn("rand_txn");
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          ms_pulse(16'($urandom()), 16'($urandom()), 8'($urandom()), 8'($urandom()));
        end
        check_frozen("rand_hold");
        end_txn("rand_txn", 1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
                8'($urandom()), 8'($urandom()));
      end
    end

    // Drive acc_x to 0x7FFFFFF0, then cross the positive limit with +1 reports
    mouse_clear();
    bus.ms_dy = '0; bus.ms_dwheel = '0; bus.ms_buttons = 8'h00;
    bus.ms_dx = 16'd32767;
    bus.ms_report_valid = 1'b1;
    repeat (65537) begin
      tick();
      m_x = m_add(m_x, 32767);
    end
    bus.ms_dx = 16'd32753;
    tick();
    m_x = m_add(m_x, 32753);
    bus.ms_report_valid = 1'b0;
    tick();
    ox = bus.hid_mouse_x;
    chk("ovf.base", ox, 32'h7FFFFFF0);
    bus.ms_dx = 16'd1;
    bus.ms_report_valid = 1'b1;
    repeat (16) begin
      tick();
      m_x = m_add(m_x, 1);
    end
    bus.ms_report_valid = 1'b0;
    tick();
`ifdef HID_SCHED_SATURATE_EN
    ov_exp = 32'h7FFFFFFF;
`else
    ov_exp = 32'h80000000;
`endif
    ox = bus.hid_mouse_x;
    chk("ovf.x", ox, ov_exp);
    check_live("ovf");

    // Reset mid-HOLD
    mouse_clear();
    ms_pulse(16'd100, 16'd0, 8'd0, 8'h03);
    tick();
    begin_txn("rst");
    ox = bus.hid_mouse_x;
    chk("rst.hold_x", ox, 32'd100);
    reset = 1'b1;
    bus.hid_read = 1'b0;
    tick();
    check_outputs("rst", '0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("rst.busy", bus.snapshot_busy, 1'b0);
    reset = 1'b0;
    m_x = 0; m_y = 0; m_w = 0; m_btn = '0; m_kmod = '0; m_keys = '0;
    repeat (SS + 2) tick();
    chk("rst.busy_idle", bus.snapshot_busy, 1'b0);
    check_live("rst.idle");
    ms_pulse(16'd3, 16'd0, 8'd0, 8'h00);
    tick();
    ox = bus.hid_mouse_x;
    chk("rst.track_x", ox, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hid_report_scheduler.md
# hid_report_scheduler

Clock-domain-side controller that owns the HID status presented to `spi_io`. Merges keyboard and mouse reports from the USB HID host cores into 32-bit accumulators and freezes a coherent snapshot for the whole SPI transaction. On transaction end it subtracts the consumed motion, so no mouse delta is lost or double-reported. Sits between the HID host cores and the `hid_*` inputs of `spi_io`; its read request comes from `spi_io.hid_read`.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — synchronizer depth for `hid_read`; legal values ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `hid_read`  in  1  asynchronous level from `spi_io` (high = SPI transaction active)
- `kb_connected`  in  1  keyboard present
- `kb_report_valid`  in  1  one-cycle pulse: new keyboard report
- `kb_modifiers`  in  8  report modifiers
- `kb_keycodes`  in  8×[0:5]  report keycodes
- `ms_connected`  in  1  mouse present
- `ms_report_valid`  in  1  one-cycle pulse: new mouse report
- `ms_buttons`  in  8  button bitmap
- `ms_dx`, `ms_dy`  in  16 signed  relative motion
- `ms_dwheel`  in  8 signed  wheel delta
- `hid_keyboard_connected`, `hid_mouse_connected`  out  1  to `spi_io`
- `hid_keyboard_modifiers`  out  8
- `hid_keyboard_keycodes`  out  8×[0:5]
- `hid_mouse_buttons`  out  8
- `hid_mouse_x`, `hid_mouse_y`, `hid_mouse_wheel`  out  32 signed  accumulated motion
- `snapshot_busy`  out  1  high in CAPTURE/HOLD/COMMIT

## Operation
- Live state: kb regs load on `kb_report_valid`. Mouse buttons load on `ms_report_valid`. `acc_x/y/w` += sign-extended delta on `ms_report_valid`.
- Disconnect: `kb_connected`=0 zeroes kb regs, ignoring valid. `ms_connected`=0 zeroes buttons and accumulators, ignoring valid.
- `rd_s` = `hid_read` after `SYNC_STAGES` flops. FSM is level-driven, so an edge is never lost.
  - IDLE: outputs ← live state every cycle. `rd_s`=1 → CAPTURE.
  - CAPTURE (1 cycle): outputs and snapshot regs `snap_x/y/w` ← live state. → HOLD.
  - HOLD: all outputs frozen. `rd_s`=0 → COMMIT.
  - COMMIT (1 cycle): `acc` ← `acc − snap` (+ delta if a report arrives that cycle). Outputs stay frozen. → IDLE.
- Accumulation continues in every state; only the outputs freeze.
- Disconnect during HOLD/COMMIT: accumulators clear, `snap` is ignored at COMMIT (result 0 + any same-cycle delta), and frozen outputs are unchanged until IDLE.
- Reset in any state: FSM → IDLE; all regs, sync flops and outputs → 0.

## Timing
- Reset value of every output: 0 (`snapshot_busy`=0).
- `hid_read` rise → outputs frozen at clk edge `SYNC_STAGES`+1. `snapshot_busy` rises at the same edge.
- `spi_io` samples status ≥ 12 sclk edges after CS fall, so `clk` ≥ 1 × sclk frequency is required with `SYNC_STAGES`=2.
- `hid_read` fall → COMMIT at edge `SYNC_STAGES`+1. IDLE and `snapshot_busy`=0 one edge later.
- A `hid_read` high or low interval shorter than `SYNC_STAGES`+1 clk may be missed. This is legal, and there is no partial commit.
- Report-to-output latency in IDLE: 2 clk (accumulate, then output register).
- Arithmetic: 32-bit signed. Deltas are sign-extended. Overflow behaviour is set by the configuration macro.

## Configuration
- `HID_SCHED_SATURATE_EN` defined: accumulator add and COMMIT subtract saturate at +2147483647 / −2147483648.
- Undefined: two's-complement wrap.
- Either way, COMMIT uses the same operator as accumulation.

## Test plan
- Reset: assert `reset` mid-HOLD with `acc_x`=100 → next edge all outputs 0, `snapshot_busy`=0, state IDLE.
- Mouse reports dx=+5 then dx=−3 in IDLE → `hid_mouse_x`=2 two clk after the second pulse.
- Raise `hid_read` with `acc_x`=10; deliver dx=+7 during HOLD → `hid_mouse_x` stays 10; after `hid_read` falls and COMMIT, `hid_mouse_x`=7.
- dx=+4 arriving exactly in the COMMIT cycle with acc=10, snap=10 → `acc_x`=4.
- Overflow, acc_x=0x7FFFFFF0 plus 16 reports of dx=+1: with the macro, `hid_mouse_x`=0x7FFFFFFF; without it, `hid_mouse_x`=0x80000000.
- Drop `ms_connected` during HOLD with acc_x=50 → frozen output stays 50; after IDLE, `hid_mouse_x`=0 and `hid_mouse_connected`=0.
